adder_result_stage: RTL and testbench

//  Registered downstream stage for the 32-bit combinational adders (carry-select, ripple, ...).

---
 rtl/adder_pkg.sv | 26 ++
 rtl/skid_buffer.sv | 57 +++++
 rtl/adder_result_stage.sv | 86 ++++++++
 tb/tb_adder_result_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and flag derivation for the adder result stage and its scoreboards.
package adder_pkg;

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned ADD_W  = 32;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } add_flags_t;

   function automatic add_flags_t calc_flags(input logic [ADD_W-1:0] a,
                                             input logic [ADD_W-1:0] b,
                                             input logic [ADD_W-1:0] s,
                                             input logic             cout);
      add_flags_t f;
      f.z = (s == '0);
      f.n = s[ADD_W-1];
      f.c = cout;
      f.v = (a[ADD_W-1] == b[ADD_W-1]) && (s[ADD_W-1] != a[ADD_W-1]);
      return f;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-slot (main + skid) valid/ready register stage; never drops a word under back-pressure.
module skid_buffer
   import adder_pkg::*;
#(
   parameter int unsigned DW = 36
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          r_main_vld;
   logic          r_skid_vld;
   logic [DW-1:0] r_main_data;
   logic [DW-1:0] r_skid_data;
   logic          w_accept;
   logic          w_deliver;

   // Ready only depends on the skid slot, so upstream never sees a combinational path from out_ready.
   assign in_ready  = rst_n & ~r_skid_vld;
   assign w_accept  = in_valid & in_ready;
   assign w_deliver = r_main_vld & out_ready;
   assign out_valid = r_main_vld;
   assign out_data  = r_main_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main_vld  <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_main_data <= '0;
         r_skid_data <= '0;
      end else if (!r_main_vld || w_deliver) begin
         if (r_skid_vld) begin
            r_main_data <= r_skid_data;
            r_main_vld  <= 1'b1;
            r_skid_vld  <= w_accept;
            if (w_accept) begin
               r_skid_data <= in_data;
            end
         end else begin
            r_main_vld <= w_accept;
            if (w_accept) begin
               r_main_data <= in_data;
            end
         end
      end else if (w_accept) begin
         r_skid_data <= in_data;
         r_skid_vld  <= 1'b1;
      end
   end

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit adders: flags, skid-buffered handshake, run counters.
module adder_result_stage
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_s,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [3:0]       out_flags,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] result_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam int unsigned DW = WIDTH + FLAG_W;

   add_flags_t       w_in_flags;
   add_flags_t       w_out_flags;
   logic [DW-1:0]    w_in_data;
   logic [DW-1:0]    w_out_data;
   logic             w_deliver;
   logic [CNT_W-1:0] r_result_cnt;
   logic [CNT_W-1:0] r_ovf_cnt;

   // The shared helper is fixed at the adder width; other widths use the same equations inline.
   generate
      if (WIDTH == ADD_W) begin : g_pkg_flags
         assign w_in_flags = calc_flags(in_a, in_b, in_s, in_cout);
      end else begin : g_local_flags
         assign w_in_flags.z = (in_s == '0);
         assign w_in_flags.n = in_s[WIDTH-1];
         assign w_in_flags.c = in_cout;
         assign w_in_flags.v = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                               (in_s[WIDTH-1] != in_a[WIDTH-1]);
      end
   endgenerate

   assign w_in_data = {in_s, w_in_flags};

   skid_buffer #(
      .DW(DW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (w_in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (w_out_data)
   );

   assign out_sum     = w_out_data[DW-1:FLAG_W];
   assign w_out_flags = add_flags_t'(w_out_data[FLAG_W-1:0]);
   assign out_flags   = w_out_flags;
   assign w_deliver   = out_valid & out_ready;

   // Clear wins over a same-cycle delivery; both counters stick at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
         r_result_cnt <= '0;
         r_ovf_cnt    <= '0;
      end else if (w_deliver) begin
         if (r_result_cnt != '1) begin
            r_result_cnt <= r_result_cnt + CNT_W'(1);
         end
         if (w_out_flags.v && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
         end
      end
   end

   assign result_cnt = r_result_cnt;
   assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed and randomised checks of adder_result_stage with 4-bit counters.
module tb_adder_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] in_s;
   logic        in_cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic [3:0]  out_flags;
   logic        clr_cnt;
   logic [3:0]  result_cnt;
   logic [3:0]  ovf_cnt;

   int errors = 0;
   int checks = 0;

   adder_result_stage #(
      .WIDTH(32),
      .CNT_W(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_s      (in_s),
      .in_cout   (in_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_flags (out_flags),
      .clr_cnt   (clr_cnt),
      .result_cnt(result_cnt),
      .ovf_cnt   (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic co);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_s     = s;
      in_cout  = co;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_flags !== 4'h0) begin
         errors++;
         $display("FAIL reset_out: got v=%b sum=%h fl=%h want 0/0/0", out_valid, out_sum, out_flags);
      end
      checks++;
      if (result_cnt !== 4'h0 || ovf_cnt !== 4'h0) begin
         errors++;
         $display("FAIL reset_cnt: got %h/%h want 0/0", result_cnt, ovf_cnt);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_single_overflow();
      out_ready = 1'b1;
      drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h8000_0000 || out_flags !== 4'b0101) begin
         errors++;
         $display("FAIL single_ovf: got v=%b sum=%h fl=%b want 1/80000000/0101",
                  out_valid, out_sum, out_flags);
      end
      tick();
      checks++;
      if (result_cnt !== 4'd1 || ovf_cnt !== 4'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_cnt: got res=%0d ovf=%0d v=%b want 1/1/0", result_cnt, ovf_cnt,
                  out_valid);
      end
   endtask

   task automatic test_zero_carry();
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_flags !== 4'b1010) begin
         errors++;
         $display("FAIL zero_carry: got v=%b sum=%h fl=%b want 1/0/1010", out_valid, out_sum,
                  out_flags);
      end
      tick();
      checks++;
      if (result_cnt !== 4'd2 || ovf_cnt !== 4'd1) begin
         errors++;
         $display("FAIL zero_carry_cnt: got %0d/%0d want 2/1", result_cnt, ovf_cnt);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(1'b1, 32'd1, 32'd2, 32'd3, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'd3 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: got v=%b sum=%h rdy=%b want 1/3/1", out_valid, out_sum, in_ready);
      end
      drive(1'b1, 32'd10, 32'd20, 32'd30, 1'b0);
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_sum !== 32'd3) begin
         errors++;
         $display("FAIL bp_full: got rdy=%b sum=%h want 0/3", in_ready, out_sum);
      end
      drive(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0 || out_sum !== 32'd3 || out_flags !== 4'b0000 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: got rdy=%b sum=%h fl=%b v=%b want 0/3/0000/1",
                  in_ready, out_sum, out_flags, out_valid);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_sum !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got sum=%h v=%b rdy=%b want 1e/1/1", out_sum, out_valid, in_ready);
      end
      tick();
      checks++;
      if (out_sum !== 32'h0 || out_flags !== 4'b1011 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_third: got sum=%h fl=%b v=%b want 0/1011/1", out_sum, out_flags, out_valid);
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b0 || result_cnt !== 4'd5 || ovf_cnt !== 4'd2) begin
         errors++;
         $display("FAIL bp_drain: got v=%b res=%0d ovf=%0d want 0/5/2", out_valid, result_cnt, ovf_cnt);
      end
   endtask

   task automatic test_saturation_clear();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'd1, 32'd1, 32'd2, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      checks++;
      if (result_cnt !== 4'hF || ovf_cnt !== 4'd2) begin
         errors++;
         $display("FAIL saturate: got res=%h ovf=%h want f/2", result_cnt, ovf_cnt);
      end
      drive(1'b1, 32'd4, 32'd5, 32'd9, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_setup: got v=%b want 1", out_valid); end
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      checks++;
      if (result_cnt !== 4'h0 || ovf_cnt !== 4'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_with_deliver: got res=%h ovf=%h v=%b want 0/0/0", result_cnt, ovf_cnt,
                  out_valid);
      end
      drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      checks++;
      if (result_cnt !== 4'd1 || ovf_cnt !== 4'd1) begin
         errors++;
         $display("FAIL after_clr: got res=%0d ovf=%0d want 1/1", result_cnt, ovf_cnt);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'd7, 32'd8, 32'd15, 1'b0);
      tick();
      drive(1'b1, 32'd9, 32'd9, 32'd18, 1'b0);
      tick();
      rst_n = 1'b0;
      drive(1'b1, 32'd1, 32'd1, 32'd2, 1'b0);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 32'h0 || result_cnt !== 4'h0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b sum=%h res=%h want 0/0/0", out_valid, out_sum, result_cnt);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_random();
      logic [35:0] q[$];
      logic [35:0] exp_w;
      logic [31:0] a, b, s;
      logic        cin, co;
      logic [3:0]  f;
      int          ndel = 0;
      int          novf = 0;
      int          nacc = 0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      for (int i = 0; i < 10008; i++) begin
         a   = $urandom;
         b   = $urandom;
         cin = 1'($urandom_range(0, 1));
         {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
         if (i < 10000) begin
            drive(($urandom_range(0, 3) != 0), a, b, s, co);
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            drive(1'b0, a, b, s, co);
            out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious: got sum=%h with empty model want no word", out_sum);
            end else begin
               exp_w = q.pop_front();
               if ({out_sum, out_flags} !== exp_w) begin
                  errors++;
                  $display("FAIL rnd_word %0d: got %h/%b want %h/%b", ndel, out_sum, out_flags,
                           exp_w[35:4], exp_w[3:0]);
               end
               ndel++;
               if (exp_w[0]) novf++;
            end
         end
         if (in_valid && in_ready) begin
            f = {(s == 32'h0), s[31], co, (a[31] == b[31]) && (s[31] != a[31])};
            q.push_back({s, f});
            nacc++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (q.size() != 0 || ndel != nacc) begin
         errors++;
         $display("FAIL rnd_loss: got delivered=%0d want %0d", ndel, nacc);
      end
      checks++;
      if (result_cnt !== 4'((ndel > 15) ? 15 : ndel) || ovf_cnt !== 4'((novf > 15) ? 15 : novf)) begin
         errors++;
         $display("FAIL rnd_cnt: got res=%0d ovf=%0d want %0d/%0d", result_cnt, ovf_cnt,
                  (ndel > 15) ? 15 : ndel, (novf > 15) ? 15 : novf);
      end
   endtask

   initial begin
      test_reset();
      test_single_overflow();
      test_zero_carry();
      test_back_to_back();
      test_saturation_clear();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
